// File: rtl/matrix_stream_out.sv
// matrix_stream_out: streams the active m x n elements of a packed row-major
// result matrix, one element per valid/ready transfer, in row-major order.
// Optional build macro MATRIX_STREAM_DIMCHECK_EN: reject out-of-range dimensions
// with an err pulse instead of clamping them.
module matrix_stream_out #(
    parameter int MAX_DIM    = 5,
    parameter int ELEM_WIDTH = 8
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  start,
    input  logic [2:0]                            m,
    input  logic [2:0]                            n,
    input  logic [MAX_DIM*MAX_DIM*ELEM_WIDTH-1:0] matrix_in,
    output logic [ELEM_WIDTH-1:0]                 elem_out,
    output logic                                  elem_valid,
    input  logic                                  elem_ready,
    output logic [2:0]                            row_idx,
    output logic [2:0]                            col_idx,
    output logic                                  row_last,
    output logic                                  last,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  err
);
    localparam int         BUS_W   = MAX_DIM * MAX_DIM * ELEM_WIDTH;
    localparam logic [2:0] DIM_MAX = 3'(MAX_DIM);

    typedef enum logic [1:0] {IDLE, SEND, FINISH} state_t;

    state_t                  state_q, state_d;
    logic [BUS_W-1:0]        mat_q, mat_d;
    logic [2:0]              m_last_q, m_last_d, n_last_q, n_last_d;
    logic [ELEM_WIDTH-1:0]   elem_q, elem_d;
    logic [2:0]              row_q, row_d, col_q, col_d;
    logic                    row_last_q, row_last_d, last_q, last_d;
    logic                    valid_q, valid_d, busy_q, busy_d;
    logic                    done_q, done_d, err_q, err_d;

    logic [2:0]              m_eff, n_eff, next_row, next_col;
    logic                    dim_bad;

    // Element (r,c) lives at bit offset (r*MAX_DIM+c)*ELEM_WIDTH.
    function automatic logic [ELEM_WIDTH-1:0] pick(input logic [BUS_W-1:0] bus,
                                                   input logic [2:0] r,
                                                   input logic [2:0] c);
        int unsigned off;
        off = (32'(r) * MAX_DIM + 32'(c)) * ELEM_WIDTH;
        return ELEM_WIDTH'(bus >> off);
    endfunction

    // Resolve requested dimensions: reject or clamp depending on the build.
    always_comb begin
        dim_bad = 1'b0;
        m_eff   = m;
        n_eff   = n;
`ifdef MATRIX_STREAM_DIMCHECK_EN
        dim_bad = (m == 3'd0) || (n == 3'd0) || (m > DIM_MAX) || (n > DIM_MAX);
`else
        if (m == 3'd0)        m_eff = 3'd1;
        else if (m > DIM_MAX) m_eff = DIM_MAX;
        if (n == 3'd0)        n_eff = 3'd1;
        else if (n > DIM_MAX) n_eff = DIM_MAX;
`endif
    end

    // Next-state logic: snapshot on start, advance one element per transfer.
    always_comb begin
        state_d    = state_q;
        mat_d      = mat_q;
        m_last_d   = m_last_q;
        n_last_d   = n_last_q;
        elem_d     = elem_q;
        row_d      = row_q;
        col_d      = col_q;
        row_last_d = row_last_q;
        last_d     = last_q;
        valid_d    = valid_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        next_row   = row_q;
        next_col   = col_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (dim_bad) begin
                        err_d = 1'b1;
                    end else begin
                        state_d    = SEND;
                        mat_d      = matrix_in;
                        m_last_d   = m_eff - 3'd1;
                        n_last_d   = n_eff - 3'd1;
                        elem_d     = pick(matrix_in, 3'd0, 3'd0);
                        row_d      = 3'd0;
                        col_d      = 3'd0;
                        row_last_d = (n_eff == 3'd1);
                        last_d     = (m_eff == 3'd1) && (n_eff == 3'd1);
                        valid_d    = 1'b1;
                        busy_d     = 1'b1;
                    end
                end
            end
            SEND: begin
                // elem_valid is always high here, so elem_ready alone marks a transfer.
                if (elem_ready) begin
                    if (last_q) begin
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = FINISH;
                    end else begin
                        if (col_q == n_last_q) begin
                            next_col = 3'd0;
                            next_row = row_q + 3'd1;
                        end else begin
                            next_col = col_q + 3'd1;
                        end
                        row_d      = next_row;
                        col_d      = next_col;
                        elem_d     = pick(mat_q, next_row, next_col);
                        row_last_d = (next_col == n_last_q);
                        last_d     = (next_row == m_last_q) && (next_col == n_last_q);
                    end
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            mat_q      <= '0;
            m_last_q   <= '0;
            n_last_q   <= '0;
            elem_q     <= '0;
            row_q      <= '0;
            col_q      <= '0;
            row_last_q <= 1'b0;
            last_q     <= 1'b0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            mat_q      <= mat_d;
            m_last_q   <= m_last_d;
            n_last_q   <= n_last_d;
            elem_q     <= elem_d;
            row_q      <= row_d;
            col_q      <= col_d;
            row_last_q <= row_last_d;
            last_q     <= last_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign elem_out   = elem_q;
    assign elem_valid = valid_q;
    assign row_idx    = row_q;
    assign col_idx    = col_q;
    assign row_last   = row_last_q;
    assign last       = last_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
endmodule
